// File: rtl/rtc_sched_pkg.sv
// Shared types and constants for the multi-slot periodic alarm scheduler.
package rtc_sched_pkg;

  // Arbiter FSM encoding.
  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_e;

  localparam int DEF_N_SLOTS  = 4;
  localparam int DEF_CNT_SIZE = 16;

  // Slot index width for a given slot count (at least one bit).
  function automatic int calc_slot_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rtc_sched_rr_pick.sv
// Combinational round-robin finder: first set request bit at or above
// start_i, wrapping past the top of the vector.
module rtc_sched_rr_pick
  import rtc_sched_pkg::*;
#(
  parameter int N = DEF_N_SLOTS,
  parameter int W = calc_slot_w(DEF_N_SLOTS)
) (
  input  logic [N-1:0] req_i,
  input  logic [W-1:0] start_i,
  output logic         valid_o,
  output logic [W-1:0] idx_o
);

  logic [N-1:0] rot;
  logic [W:0]   sum;

  // Rotate the requests so start_i lands on bit 0, take the lowest set bit,
  // then map the offset back to an absolute slot index modulo N.
  always_comb begin
    rot     = N'({req_i, req_i} >> start_i);
    valid_o = 1'b0;
    sum     = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (rot[k]) begin
        valid_o = 1'b1;
        sum     = {1'b0, start_i} + (W+1)'(k);
      end
    end
    if (sum >= (W+1)'(N)) begin
      sum = sum - (W+1)'(N);
    end
    idx_o = sum[W-1:0];
  end

endmodule

// File: rtl/rtc_sched.sv
// Multi-slot periodic alarm scheduler. Each slot counts shared ticks down
// from its period and raises a pending flag when it wraps; pending slots are
// granted round-robin onto a single interrupt line.
//
// Interrupt handshake: int_o rises with int_vec_o naming the granted slot and
// both hold steady until the core samples int_ack_i=1 (pending of that slot
// clears, int_o drops the next cycle) or software disables the granted slot
// (grant withdrawn, ack ignored). int_o is always low for at least one cycle
// between grants; int_ack_i outside a grant has no effect.
module rtc_sched
  import rtc_sched_pkg::*;
#(
  parameter int N_SLOTS  = DEF_N_SLOTS,
  parameter int CNT_SIZE = DEF_CNT_SIZE,
  parameter int SLOT_W   = calc_slot_w(DEF_N_SLOTS)
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                tick_i,
  input  logic                cfg_wr_i,
  input  logic [SLOT_W-1:0]   cfg_slot_i,
  input  logic [CNT_SIZE-1:0] cfg_period_i,
  input  logic                cfg_en_i,
  output logic                int_o,
  output logic [SLOT_W-1:0]   int_vec_o,
  input  logic                int_ack_i,
  output logic [N_SLOTS-1:0]  pending_o,
  output logic [N_SLOTS-1:0]  overrun_o
);

  state_e              state_q, state_d;
  logic [CNT_SIZE-1:0] period_q [N_SLOTS];
  logic [CNT_SIZE-1:0] period_d [N_SLOTS];
  logic [CNT_SIZE-1:0] count_q  [N_SLOTS];
  logic [CNT_SIZE-1:0] count_d  [N_SLOTS];
  logic [N_SLOTS-1:0]  en_q, en_d;
  logic [N_SLOTS-1:0]  pending_q, pending_d;
  logic [N_SLOTS-1:0]  overrun_q, overrun_d;
  logic                int_q, int_d;
  logic [SLOT_W-1:0]   vec_q, vec_d;
  logic [SLOT_W-1:0]   rr_q, rr_d;

  logic [N_SLOTS-1:0]  wr_hit, wr_clr, ack_hit, fire, req;
  logic                withdraw, ack_take, pick_valid;
  logic [SLOT_W-1:0]   pick_idx;

  // A write disabling the granted slot withdraws the grant and masks any ack.
  assign withdraw = (state_q == ST_GRANT) && cfg_wr_i && !cfg_en_i && (cfg_slot_i == vec_q);
  assign ack_take = (state_q == ST_GRANT) && int_ack_i && !withdraw;

  // Per-slot decode of config writes and the accepted acknowledge.
  always_comb begin
    wr_hit  = '0;
    ack_hit = '0;
    for (int s = 0; s < N_SLOTS; s++) begin
      wr_hit[s]  = cfg_wr_i && (cfg_slot_i == SLOT_W'(s));
      ack_hit[s] = ack_take && (vec_q == SLOT_W'(s));
    end
    wr_clr = wr_hit & {N_SLOTS{~cfg_en_i}};
  end

  // Slots being cleared by a disabling write this cycle are not offered.
  assign req = pending_q & ~wr_clr;

  rtc_sched_rr_pick #(
    .N (N_SLOTS),
    .W (SLOT_W)
  ) u_rr_pick (
    .req_i   (req),
    .start_i (rr_q),
    .valid_o (pick_valid),
    .idx_o   (pick_idx)
  );

  // Period/count/enable update: a write reloads the slot and hides the tick
  // from it; otherwise an enabled non-zero period counts down and fires on 0.
  always_comb begin
    period_d = period_q;
    count_d  = count_q;
    en_d     = en_q;
    fire     = '0;
    for (int s = 0; s < N_SLOTS; s++) begin
      if (wr_hit[s]) begin
        period_d[s] = cfg_period_i;
        en_d[s]     = cfg_en_i;
        if (cfg_period_i == '0) begin
          count_d[s] = '0;
        end else begin
          count_d[s] = cfg_period_i - CNT_SIZE'(1);
        end
      end else if (tick_i && en_q[s] && (period_q[s] != '0)) begin
        if (count_q[s] == '0) begin
          count_d[s] = period_q[s] - CNT_SIZE'(1);
          fire[s]    = 1'b1;
        end else begin
          count_d[s] = count_q[s] - CNT_SIZE'(1);
        end
      end
    end
  end

  // Pending/overrun flags: ack clears, fire sets (fire wins over a same-slot
  // ack without overrun), a write clears overrun and, if disabling, pending.
  always_comb begin
    pending_d = pending_q;
    overrun_d = overrun_q;
    for (int s = 0; s < N_SLOTS; s++) begin
      if (ack_hit[s]) begin
        pending_d[s] = 1'b0;
      end
      if (fire[s]) begin
        pending_d[s] = 1'b1;
        if (pending_q[s] && !ack_hit[s]) begin
          overrun_d[s] = 1'b1;
        end
      end
      if (wr_hit[s]) begin
        overrun_d[s] = 1'b0;
        if (!cfg_en_i) begin
          pending_d[s] = 1'b0;
        end
      end
    end
  end

  // Arbiter next state: grant from IDLE, release on ack or withdrawal.
  always_comb begin
    state_d = state_q;
    int_d   = int_q;
    vec_d   = vec_q;
    rr_d    = rr_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_valid) begin
          state_d = ST_GRANT;
          int_d   = 1'b1;
          vec_d   = pick_idx;
        end
      end
      ST_GRANT: begin
        if (withdraw) begin
          state_d = ST_IDLE;
          int_d   = 1'b0;
        end else if (int_ack_i) begin
          state_d = ST_IDLE;
          int_d   = 1'b0;
          rr_d    = (vec_q == SLOT_W'(N_SLOTS - 1)) ? '0 : vec_q + SLOT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        int_d   = 1'b0;
      end
    endcase
  end

  // All state registers, synchronous active-high reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int s = 0; s < N_SLOTS; s++) begin
        period_q[s] <= '0;
        count_q[s]  <= '0;
      end
      en_q      <= '0;
      pending_q <= '0;
      overrun_q <= '0;
      state_q   <= ST_IDLE;
      int_q     <= 1'b0;
      vec_q     <= '0;
      rr_q      <= '0;
    end else begin
      for (int s = 0; s < N_SLOTS; s++) begin
        period_q[s] <= period_d[s];
        count_q[s]  <= count_d[s];
      end
      en_q      <= en_d;
      pending_q <= pending_d;
      overrun_q <= overrun_d;
      state_q   <= state_d;
      int_q     <= int_d;
      vec_q     <= vec_d;
      rr_q      <= rr_d;
    end
  end

  assign int_o     = int_q;
  assign int_vec_o = vec_q;
  assign pending_o = pending_q;
  assign overrun_o = overrun_q;

endmodule
